// File: rtl/irq_ctrl.sv
// Three-source interrupt controller: edge-latched requests, fixed priority, toggle-coded IRQ lines.
// Define IRQC_TIMER_EN to add the internal periodic timer as a second timer event source.
module irq_ctrl #(
  parameter logic [15:0] MASK_ADDR = 16'hFFF0,
  parameter logic [15:0] EOI_ADDR  = 16'hFFF1,
  parameter logic [15:0] TIMER_DIV = 16'd25000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [15:0] I_ADDR,
  input  logic [7:0]  I_DATA,
  input  logic        I_WREN,
  input  logic        EV_KEYB,
  input  logic        EV_MOUSE,
  input  logic        EV_TIMER,
  output logic        O_IRQ_KEYB,
  output logic        O_IRQ_MOUSE,
  output logic        O_IRQ_TIMER,
  output logic [2:0]  O_PENDING,
  output logic [2:0]  O_INSERV
);

  logic [2:0] ev_q;
  logic [2:0] pending;
  logic [2:0] inserv;
  logic [2:0] mask;
  logic [2:0] irq;
  logic [2:0] ev;
  logic [2:0] rise;
  logic [2:0] avail;
  logic [2:0] disp;
  logic       mask_wr;
  logic       eoi_wr;
  logic       tick;
  logic       unused_data;

  assign ev      = {EV_TIMER, EV_MOUSE, EV_KEYB};
  assign mask_wr = I_WREN && (I_ADDR == MASK_ADDR);
  assign eoi_wr  = I_WREN && (I_ADDR == EOI_ADDR);

`ifdef IRQC_TIMER_EN
  logic [15:0] cnt;
  logic        tmr_en;

  assign tick        = tmr_en && (cnt == TIMER_DIV - 16'd1);
  assign unused_data = ^I_DATA[7:4];

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt    <= '0;
      tmr_en <= 1'b0;
    end else begin
      if (mask_wr) tmr_en <= I_DATA[3];
      if (!tmr_en || tick) cnt <= '0;
      else                 cnt <= cnt + 16'd1;
    end
  end
`else
  assign tick        = 1'b0;
  assign unused_data = ^I_DATA[7:3];
`endif

  assign rise  = (ev & ~ev_q) | {tick, 2'b00};
  assign avail = pending & ~mask;

  // Dispatch looks at pre-write state; only one source per edge.
  always_comb begin
    disp = 3'b000;
    if (inserv == 3'b000) begin
      if (avail[0])      disp = 3'b001;
      else if (avail[1]) disp = 3'b010;
      else if (avail[2]) disp = 3'b100;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ev_q    <= '0;
      pending <= '0;
      inserv  <= '0;
      mask    <= 3'b111;
      irq     <= '0;
    end else begin
      ev_q    <= ev;
      pending <= (pending & ~disp) | rise;
      inserv  <= (inserv & ~(eoi_wr ? I_DATA[2:0] : 3'b000)) | disp;
      irq     <= irq ^ disp;
      if (mask_wr) mask <= I_DATA[2:0];
    end
  end

  assign O_IRQ_KEYB  = irq[0];
  assign O_IRQ_MOUSE = irq[1];
  assign O_IRQ_TIMER = irq[2];
  assign O_PENDING   = pending;
  assign O_INSERV    = inserv;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expected IRQ toggles (source, edge) are queued at
// stimulus time and matched by a negedge monitor.
module tb_irq_ctrl;

  localparam logic [15:0] MA = 16'hFFF0;
  localparam logic [15:0] EA = 16'hFFF1;

  typedef struct {
    int src;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  data = '0;
  logic        wren = 1'b0;
  logic        ev_k = 1'b0;
  logic        ev_m = 1'b0;
  logic        ev_t = 1'b0;
  logic        irq_k;
  logic        irq_m;
  logic        irq_t;
  logic [2:0]  pend;
  logic [2:0]  insv;

  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  bit   in_rst = 1'b1;
  exp_t sb[$];
  logic [2:0] prev = '0;

  irq_ctrl #(
    .MASK_ADDR(MA),
    .EOI_ADDR (EA),
    .TIMER_DIV(16'd4)
  ) dut (
    .CLOCK      (clk),
    .RESET      (rst),
    .I_ADDR     (addr),
    .I_DATA     (data),
    .I_WREN     (wren),
    .EV_KEYB    (ev_k),
    .EV_MOUSE   (ev_m),
    .EV_TIMER   (ev_t),
    .O_IRQ_KEYB (irq_k),
    .O_IRQ_MOUSE(irq_m),
    .O_IRQ_TIMER(irq_t),
    .O_PENDING  (pend),
    .O_INSERV   (insv)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] cur;
    exp_t e;
    cur = {irq_t, irq_m, irq_k};
    if (!in_rst) begin
      for (int b = 0; b < 3; b++) begin
        if (cur[b] != prev[b]) begin
          if (sb.size() == 0) begin
            check("unexpected_toggle", b, -1);
          end else begin
            e = sb.pop_front();
            check("toggle_src", b, e.src);
            check("toggle_edge", cyc, e.cyc);
          end
        end
      end
    end
    prev = cur;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int src, input int edge_no);
    exp_t e;
    e.src = src;
    e.cyc = edge_no;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    addr = a;
    data = d;
    wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] v);
    {ev_t, ev_m, ev_k} = v;
    @(negedge clk);
    {ev_t, ev_m, ev_k} = 3'b000;
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_pend", pend, 0);
    check("rst_insv", insv, 0);
    check("rst_irq", {irq_t, irq_m, irq_k}, 0);

    // single keyb request
    wr(MA, 8'h00);
    expect_at(0, cyc + 2);
    pulse(3'b001);
    check("k_pend", pend, 3'b001);
    tick(1);
    check("k_insv", insv, 3'b001);
    check("k_pend2", pend, 0);
    wr(EA, 8'h01);
    check("k_eoi", insv, 0);

    // simultaneous requests resolved by priority
    expect_at(0, cyc + 2);
    pulse(3'b111);
    check("p_pend", pend, 3'b111);
    tick(1);
    check("p_insv", insv, 3'b001);
    check("p_pend2", pend, 3'b110);
    tick(3);
    expect_at(1, cyc + 2);
    wr(EA, 8'h01);
    tick(1);
    check("p_insv_m", insv, 3'b010);
    expect_at(2, cyc + 2);
    wr(EA, 8'h02);
    tick(1);
    check("p_insv_t", insv, 3'b100);
    wr(EA, 8'h04);
    check("p_idle", insv, 0);

    // masked mouse stays pending
    wr(MA, 8'h02);
    pulse(3'b010);
    tick(100);
    check("m_pend", pend, 3'b010);
    check("m_insv", insv, 0);
    expect_at(1, cyc + 2);
    wr(MA, 8'h00);
    tick(1);
    check("m_insv2", insv, 3'b010);
    wr(EA, 8'h05);
    check("m_eoi_other", insv, 3'b010);
    wr(EA, 8'h02);
    check("m_eoi", insv, 0);

    // timer events merge while keyb in service
    expect_at(0, cyc + 2);
    pulse(3'b001);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      pulse(3'b100);
      tick(1);
    end
    check("t_pend", pend, 3'b100);
    wr(EA, 8'h04);
    check("t_eoi_nis", insv, 3'b001);
    check("t_eoi_pend", pend, 3'b100);
    expect_at(2, cyc + 2);
    wr(EA, 8'h01);
    tick(2);
    check("t_insv", insv, 3'b100);
    check("t_pend2", pend, 0);
    wr(EA, 8'h04);

    // reset on the would-be dispatch edge
    check("r_irq_pre", irq_k, 1);
    pulse(3'b001);
    do_reset();
    check("r_irq", {irq_t, irq_m, irq_k}, 0);
    check("r_pend", pend, 0);
    check("r_insv", insv, 0);
    pulse(3'b001);
    tick(5);
    check("r_mask_pend", pend, 3'b001);

`ifdef IRQC_TIMER_EN
    do_reset();
    begin
      int w;
      w = cyc + 1;
      wr(MA, 8'h08);
      for (int i = 0; i < 4; i++) expect_at(2, w + 5 + 4 * i);
      addr = EA;
      data = 8'h04;
      wren = 1'b1;
      tick(18);
      wren = 1'b0;
      wr(MA, 8'h0C);
      tick(30);
      check("tm_pend", pend, 3'b100);
    end
`endif

    tick(3);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter MASK_ADDR, default 16'hFFF0, meaning the CPU write address of the mask/control register.
REQ-002 SHALL have parameter EOI_ADDR, default 16'hFFF1, meaning the CPU write address of the end-of-interrupt register.
REQ-003 SHALL have parameter TIMER_DIV, default 16'd25000, meaning the internal timer period in CLOCK cycles; legal range 2..65535.
REQ-004 SHALL have port CLOCK, input, 1 bit: the single clock, 25 MHz typical.
REQ-005 SHALL have port RESET, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port I_ADDR, input, 16 bits: snooped CPU bus address.
REQ-007 SHALL have port I_DATA, input, 8 bits: snooped CPU write data.
REQ-008 SHALL have port I_WREN, input, 1 bit: snooped CPU write enable.
REQ-009 SHALL have ports EV_KEYB, EV_MOUSE and EV_TIMER, input, 1 bit each: device event requests, recognised on the rising edge.
REQ-010 SHALL have ports O_IRQ_KEYB, O_IRQ_MOUSE and O_IRQ_TIMER, output, 1 bit each: CPU IRQ lines, toggle-coded (one toggle = one request).
REQ-011 SHALL have port O_PENDING, output, 3 bits: pending latches {timer, mouse, keyb}.
REQ-012 SHALL have port O_INSERV, output, 3 bits: in-service latches {timer, mouse, keyb}.

Function
REQ-013 SHALL register each EV_x and set pending[x] on the CLOCK edge at which EV_x is sampled 1 while its registered previous value is 0.
REQ-014 SHALL merge any event arriving while pending[x] is already 1 into the existing request (one interrupt only).
REQ-015 SHALL, when pending[x] is set and pending[x] is cleared in the same cycle, leave pending[x] at 1 (set wins).
REQ-016 SHALL dispatch only when inserv == 3'b000, choosing the highest-priority source with pending & ~mask; priority is keyb > mouse > timer.
REQ-017 SHALL perform a dispatch in one edge: invert O_IRQ_x, clear pending[x], set inserv[x].
REQ-018 SHALL produce at most one dispatch per cycle, so at most one O_IRQ line changes per cycle.
REQ-019 SHALL set pending[x] at edge k and toggle O_IRQ_x at edge k+1, given an EV_x rising edge sampled at edge k with an idle, unmasked controller.
REQ-020 SHALL keep a masked source pending; clearing its mask bit allows dispatch on the next edge.
REQ-021 SHALL, on every cycle with I_WREN=1 and I_ADDR==MASK_ADDR, load mask <= I_DATA[2:0]; I_DATA[7:4] are ignored (I_DATA[3]: see REQ-030/031).
REQ-022 SHALL, on every cycle with I_WREN=1 and I_ADDR==EOI_ADDR, clear inserv &= ~I_DATA[2:0]; other bits are ignored.
REQ-023 SHALL treat mask and EOI writes as idempotent, so writes whose I_WREN stays high for several cycles are safe.
REQ-024 SHALL evaluate dispatch on pre-EOI register state, so the earliest dispatch after an EOI is one edge after the EOI edge.
REQ-025 SHALL leave inserv[x] unchanged when an EOI names a source not in service.
REQ-026 SHALL not affect pending when an EOI is written.
REQ-027 SHALL continue to latch a new event for source x while inserv[x]=1; that request is dispatched after the EOI.

Reset
REQ-028 SHALL, when RESET=1 at an edge, clear pending, inserv, the EV edge registers, the timer counter and the timer enable, and drive O_IRQ_* = 0.
REQ-029 SHALL, on that reset edge, set mask = 3'b111; RESET overrides all other activity in the same cycle, including mid-dispatch and mid-EOI.

Configuration
REQ-030 SHALL, with IRQC_TIMER_EN defined, include a 16-bit counter that runs 0..TIMER_DIV-1 and wraps while the timer enable (mask-write I_DATA[3], reset 0) is 1; the counter is held at 0 while the enable is 0.
REQ-031 SHALL, with IRQC_TIMER_EN defined, treat each wrap to 0 as a timer event ORed with the EV_TIMER rising edge.
REQ-032 SHALL, without IRQC_TIMER_EN, omit the counter, ignore I_DATA[3], and take timer events from EV_TIMER only.

Verification
REQ-033 SHALL cover: mask write 8'h00, EV_KEYB pulse at edge 10 -> pending[0]=1 after edge 10, O_IRQ_KEYB 0->1 at edge 11, inserv=3'b001.
REQ-034 SHALL cover: keyb, mouse and timer pulses in the same cycle, unmasked -> keyb dispatched first; after EOI 8'h01 mouse toggles one edge later; after EOI 8'h02 timer toggles.
REQ-035 SHALL cover: mask 8'h02 then EV_MOUSE pulse -> O_PENDING=3'b010 with no toggle for 100 cycles; mask write 8'h00 -> O_IRQ_MOUSE toggles next edge.
REQ-036 SHALL cover: three EV_TIMER pulses while inserv=3'b001 -> exactly one O_IRQ_TIMER toggle after EOI 8'h01.
REQ-037 SHALL cover: RESET asserted at the dispatch edge -> outputs 0, mask=3'b111, no toggle after RESET deasserts.
REQ-038 SHALL cover, with IRQC_TIMER_EN and TIMER_DIV=4: mask write 8'h08 -> O_IRQ_TIMER toggles once per EOI'd period (4 cycles); mask write 8'h0C -> no toggles.
